// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage. Owns the PC, drives the
// word-aligned fetch address to a combinational instruction memory and
// captures the returned instruction into the IF/ID register for decode.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INST  = 32'h0000_0013,
   parameter logic [31:0] HALT_INST = 32'h0010_0073
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_inst_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_pc4_o,
   output logic [31:0] if_inst_o,
   output logic        if_valid_o,
   output logic        halted_o,
   output logic        misalign_o
);

   typedef enum logic [1:0] {RUN, HALT, TRAP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ifpc_q, ifpc_d;
   logic [31:0] ifpc4_q, ifpc4_d;
   logic [31:0] ifinst_q, ifinst_d;
   logic        ifvalid_q, ifvalid_d;
   logic        halted_q, halted_d;
   logic        misalign_q, misalign_d;

   logic [31:0] pc_plus4;
   logic        tgt_aligned;

   assign pc_plus4    = pc_q + 32'd4;   // wraps modulo 2^32
   assign tgt_aligned = (redirect_pc_i[1:0] == 2'b00);

   // Next-state: redirect > flush > stall > normal; a bubble keeps pc/pc4 of IF/ID
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ifpc_d     = ifpc_q;
      ifpc4_d    = ifpc4_q;
      ifinst_d   = ifinst_q;
      ifvalid_d  = ifvalid_q;
      halted_d   = halted_q;
      misalign_d = misalign_q;
      case (state_q)
         RUN, HALT: begin
            if (redirect_i) begin
               ifinst_d  = NOP_INST;
               ifvalid_d = 1'b0;
               if (tgt_aligned) begin
                  pc_d     = redirect_pc_i;
                  halted_d = 1'b0;
                  state_d  = RUN;
               end else begin
                  misalign_d = 1'b1;
                  state_d    = TRAP;
               end
            end else if (flush_i) begin
               ifinst_d  = NOP_INST;
               ifvalid_d = 1'b0;
               if (!stall_i && state_q == RUN) pc_d = pc_plus4;
            end else if (stall_i) begin
               // hold everything
            end else if (state_q == RUN) begin
               ifpc_d    = pc_q;
               ifpc4_d   = pc_plus4;
               ifinst_d  = imem_inst_i;
               ifvalid_d = 1'b1;
               if (imem_inst_i == HALT_INST) begin
                  // EBREAK is delivered to decode; fetch parks on it
                  halted_d = 1'b1;
                  state_d  = HALT;
               end else begin
                  pc_d = pc_plus4;
               end
            end else begin
               // halted: drain IF/ID with bubbles
               ifinst_d  = NOP_INST;
               ifvalid_d = 1'b0;
            end
         end
         default: begin
            // TRAP: frozen until reset, IF/ID bubbled every edge
            ifinst_d  = NOP_INST;
            ifvalid_d = 1'b0;
         end
      endcase
   end

   // State and pipeline registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         ifpc_q     <= 32'd0;
         ifpc4_q    <= 32'd0;
         ifinst_q   <= NOP_INST;
         ifvalid_q  <= 1'b0;
         halted_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ifpc_q     <= ifpc_d;
         ifpc4_q    <= ifpc4_d;
         ifinst_q   <= ifinst_d;
         ifvalid_q  <= ifvalid_d;
         halted_q   <= halted_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_addr_o = pc_q;
   assign if_pc_o     = ifpc_q;
   assign if_pc4_o    = ifpc4_q;
   assign if_inst_o   = ifinst_q;
   assign if_valid_o  = ifvalid_q;
   assign halted_o    = halted_q;
   assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected post-edge outputs are queued as
// stimulus is applied and compared one edge later. A second instance with a
// high RESET_PC covers the PC wrap.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, redir;
   logic [31:0] redir_pc;

   logic [31:0] addr1, inst1, pc1, pc41, ifi1;
   logic        v1, h1, m1;
   logic [31:0] addr2, inst2, pc2, pc42, ifi2;
   logic        v2, h2, m2;

   always #5 clk = ~clk;

   // Instruction memory contents: a few fixed words, otherwise an
   // address-derived non-EBREAK word.
   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h0:   mem = 32'h00A00093;
         32'h4:   mem = 32'h00100113;
         32'h20:  mem = 32'h00100073;
         default: mem = {a[19:0], 12'h093};
      endcase
   endfunction

   assign inst1 = mem(addr1);
   assign inst2 = mem(addr2);

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
      .redirect_i(redir), .redirect_pc_i(redir_pc),
      .imem_addr_o(addr1), .imem_inst_i(inst1),
      .if_pc_o(pc1), .if_pc4_o(pc41), .if_inst_o(ifi1), .if_valid_o(v1),
      .halted_o(h1), .misalign_o(m1));

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
      .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
      .redirect_i(redir), .redirect_pc_i(redir_pc),
      .imem_addr_o(addr2), .imem_inst_i(inst2),
      .if_pc_o(pc2), .if_pc4_o(pc42), .if_inst_o(ifi2), .if_valid_o(v2),
      .halted_o(h2), .misalign_o(m2));

   typedef struct {
      logic [31:0] addr, pc, pc4, inst;
      logic        valid, halted, misalign;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push1(input logic [31:0] a, p, p4, i, input logic v, h, m);
      exp_t e;
      e.addr = a; e.pc = p; e.pc4 = p4; e.inst = i;
      e.valid = v; e.halted = h; e.misalign = m;
      q1.push_back(e);
   endtask

   task automatic push2(input logic [31:0] a, p, p4, i, input logic v);
      exp_t e;
      e.addr = a; e.pc = p; e.pc4 = p4; e.inst = i;
      e.valid = v; e.halted = 1'b0; e.misalign = 1'b0;
      q2.push_back(e);
   endtask

   // One clock edge, then pop and compare whatever was queued for it.
   task automatic tick(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (q1.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = q1.pop_front();
         chk({tag, ".addr"},  addr1, e.addr);
         chk({tag, ".pc"},    pc1,   e.pc);
         chk({tag, ".pc4"},   pc41,  e.pc4);
         chk({tag, ".inst"},  ifi1,  e.inst);
         chk({tag, ".valid"}, {31'd0, v1}, {31'd0, e.valid});
         chk({tag, ".halt"},  {31'd0, h1}, {31'd0, e.halted});
         chk({tag, ".mis"},   {31'd0, m1}, {31'd0, e.misalign});
      end
      if (q2.size() != 0) begin
         e = q2.pop_front();
         chk({tag, ".hi.addr"},  addr2, e.addr);
         chk({tag, ".hi.pc"},    pc2,   e.pc);
         chk({tag, ".hi.pc4"},   pc42,  e.pc4);
         chk({tag, ".hi.inst"},  ifi2,  e.inst);
         chk({tag, ".hi.valid"}, {31'd0, v2}, {31'd0, e.valid});
      end
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redir = 1'b0; redir_pc = 32'd0;

      // reset
      push1(32'h0, 32'h0, 32'h0, 32'h13, 0, 0, 0);
      push2(32'hFFFFFFF8, 32'h0, 32'h0, 32'h13, 0);
      tick("reset");
      rst_n = 1'b1;

      // free run
      push1(32'h4, 32'h0, 32'h4, 32'h00A00093, 1, 0, 0);
      push2(32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'hFFFF8093, 1);
      tick("run1");
      push1(32'h8, 32'h4, 32'h8, 32'h00100113, 1, 0, 0);
      push2(32'h0, 32'hFFFFFFFC, 32'h0, 32'hFFFFC093, 1);
      tick("run2");

      // stall two cycles at pc=8
      stall = 1'b1;
      push1(32'h8, 32'h4, 32'h8, 32'h00100113, 1, 0, 0);
      tick("stall1");
      push1(32'h8, 32'h4, 32'h8, 32'h00100113, 1, 0, 0);
      tick("stall2");
      stall = 1'b0;
      push1(32'hC, 32'h8, 32'hC, 32'h00008093, 1, 0, 0);
      tick("resume");
      push1(32'h10, 32'hC, 32'h10, 32'h0000C093, 1, 0, 0);
      tick("run3");

      // redirect beats stall
      redir = 1'b1; redir_pc = 32'h40; stall = 1'b1;
      push1(32'h40, 32'hC, 32'h10, 32'h13, 0, 0, 0);
      tick("redir_stall");
      redir = 1'b0; stall = 1'b0;
      push1(32'h44, 32'h40, 32'h44, 32'h00040093, 1, 0, 0);
      tick("after_redir");

      // flush, then flush with stall
      flush = 1'b1;
      push1(32'h48, 32'h40, 32'h44, 32'h13, 0, 0, 0);
      tick("flush");
      stall = 1'b1;
      push1(32'h48, 32'h40, 32'h44, 32'h13, 0, 0, 0);
      tick("flush_stall");
      flush = 1'b0; stall = 1'b0;

      // EBREAK at 0x20
      redir = 1'b1; redir_pc = 32'h20;
      push1(32'h20, 32'h40, 32'h44, 32'h13, 0, 0, 0);
      tick("redir20");
      redir = 1'b0;
      push1(32'h20, 32'h20, 32'h24, 32'h00100073, 1, 1, 0);
      tick("ebreak");
      push1(32'h20, 32'h20, 32'h24, 32'h13, 0, 1, 0);
      tick("halt_bubble");
      stall = 1'b1;
      push1(32'h20, 32'h20, 32'h24, 32'h13, 0, 1, 0);
      tick("halt_stall");
      stall = 1'b0;

      // leave HALT via redirect
      redir = 1'b1; redir_pc = 32'h80;
      push1(32'h80, 32'h20, 32'h24, 32'h13, 0, 0, 0);
      tick("unhalt");
      redir = 1'b0;
      push1(32'h84, 32'h80, 32'h84, 32'h00080093, 1, 0, 0);
      tick("run80");

      // misaligned redirect -> TRAP; later inputs ignored
      redir = 1'b1; redir_pc = 32'h42;
      push1(32'h84, 32'h80, 32'h84, 32'h13, 0, 0, 1);
      tick("misalign");
      redir_pc = 32'h100;
      push1(32'h84, 32'h80, 32'h84, 32'h13, 0, 0, 1);
      tick("trap_redir");
      redir = 1'b0;
      push1(32'h84, 32'h80, 32'h84, 32'h13, 0, 0, 1);
      tick("trap_idle");

      // reset out of TRAP
      rst_n = 1'b0;
      push1(32'h0, 32'h0, 32'h0, 32'h13, 0, 0, 0);
      tick("trap_reset");
      rst_n = 1'b1;
      push1(32'h4, 32'h0, 32'h4, 32'h00A00093, 1, 0, 0);
      tick("rerun");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the single-issue RV32I core; sits directly upstream of the combinational instruction memory.
- Owns the program counter and drives the word-aligned fetch address.
- Captures the returned instruction the same cycle into the IF/ID pipeline register consumed by decode.
- Handles stall, flush, branch/jump redirect, EBREAK halt and misaligned-target trap.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) written into IF/ID on flush
HALT_INST, 32'h0010_0073, encoding (EBREAK) that halts fetch

Ports:
clk  input  1  core clock, rising-edge
rst_n  input  1  synchronous active-low reset
stall_i  input  1  hold PC and IF/ID (hazard unit)
flush_i  input  1  replace IF/ID contents with bubble
redirect_i  input  1  taken branch/jump; PC <= redirect_pc_i, IF/ID bubbled
redirect_pc_i  input  32  redirect target
imem_addr_o  output  32  fetch byte address to instruction memory (= pc register)
imem_inst_i  input  32  instruction returned combinationally for imem_addr_o
if_pc_o  output  32  PC of instruction in IF/ID
if_pc4_o  output  32  if_pc_o + 4
if_inst_o  output  32  instruction in IF/ID
if_valid_o  output  1  IF/ID holds a real instruction
halted_o  output  1  fetch halted on HALT_INST
misalign_o  output  1  sticky: redirect target not 4-byte aligned

Behaviour:
- Clock/reset: single clock clk; reset synchronous, active-low on rst_n. All state updates on rising clk only.
- Reset values: pc=RESET_PC (so imem_addr_o=RESET_PC), if_pc_o=0, if_pc4_o=0, if_inst_o=NOP_INST, if_valid_o=0, halted_o=0, misalign_o=0, state=RUN.
- imem_addr_o is the pc register directly, no combinational path from inputs. Memory is asynchronous; imem_inst_i is valid the same cycle.
- States: RUN, HALT, TRAP. Per-edge priority: reset > redirect_i > flush_i > stall_i > normal.
- RUN, redirect_i=1, redirect_pc_i[1:0]==0:
  - pc<=redirect_pc_i.
  - IF/ID<=bubble (inst=NOP_INST, valid=0, pc/pc4 hold). Applies even if stall_i=1.
- RUN, redirect_i=1, redirect_pc_i[1:0]!=0:
  - pc unchanged; IF/ID<=bubble; misalign_o<=1; state<=TRAP.
- RUN, flush_i=1, no redirect:
  - IF/ID<=bubble.
  - pc<=pc+4 unless stall_i=1, in which case pc holds.
- RUN, stall_i=1 only: pc and IF/ID hold all fields.
- RUN, normal:
  - IF/ID<={pc, pc+4, imem_inst_i, valid=1}; pc<=pc+4.
  - If imem_inst_i==HALT_INST: the EBREAK is still captured valid, pc holds, state<=HALT, halted_o<=1.
- HALT:
  - pc holds; each non-stalled edge writes a bubble into IF/ID; stall_i holds IF/ID.
  - redirect_i=1 (older branch squashing a speculative EBREAK) with aligned target: pc<=target, IF/ID bubble, halted_o<=0, state<=RUN. Misaligned target follows the TRAP rule.
- TRAP: pc frozen, IF/ID bubble every edge, all inputs ignored; exit only via reset.
- Arithmetic: pc+4 modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- Reset mid-operation: rst_n=0 at any edge overrides every other input and restores reset values, including exit from HALT/TRAP.

Test Plan:
- Reset then 4 free-running cycles, imem returns 32'h00A00093,32'h00100113,... -> imem_addr_o 0,4,8,C; IF/ID shows pc=0 inst=00A00093 valid=1 after edge 1, pc4=4.
- stall_i=1 for 2 cycles at pc=8 -> imem_addr_o stays 8, IF/ID holds pc=4 contents; resumes pc=C after release.
- redirect_i=1 with target 32'h40 while stall_i=1 at pc=10 -> next cycle imem_addr_o=40, if_valid_o=0, if_inst_o=00000013; following cycle pc=40 instruction valid.
- imem returns 32'h00100073 at pc=20 -> IF/ID pc=20 valid=1, halted_o=1, imem_addr_o stays 20, later IF/ID valid=0; then redirect to 32'h80 -> halted_o=0, fetch resumes at 80.
- redirect to 32'h42 -> misalign_o=1, pc frozen, if_valid_o=0 indefinitely; rst_n=0 one edge -> pc=0, misalign_o=0.
- Reset with RESET_PC=32'hFFFF_FFF8, run 3 cycles -> imem_addr_o FFFFFFF8, FFFFFFFC, 00000000; if_pc4_o for FFFFFFFC equals 0.
